// File: rtl/key_debounce.sv
// Four-channel push-button debouncer: 2-FF synchronizer, then a per-key
// four-state filter that only accepts a level after CNT_MAX stable samples.
module key_debounce #(
  parameter int CNT_MAX = 1000000,
  parameter int CNT_W   = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_in,
  output logic [3:0] key_out,
  output logic [3:0] key_busy
);

  typedef enum logic [1:0] {
    S_HIGH = 2'd0,
    S_FALL = 2'd1,
    S_LOW  = 2'd2,
    S_RISE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic   [3:0]       sync_r1;
  logic   [3:0]       sync_r2;
  state_t             state_r [4];
  state_t             state_s [4];
  logic   [CNT_W-1:0] cnt_r   [4];
  logic   [CNT_W-1:0] cnt_s   [4];
  logic   [3:0]       key_out_r;
  logic   [3:0]       key_busy_r;
  logic   [3:0]       out_s;
  logic   [3:0]       busy_s;

  // Two-stage synchronizer; idles high so reset looks like "nothing pressed".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r1 <= 4'b1111;
      sync_r2 <= 4'b1111;
    end else begin
      sync_r1 <= key_in;
      sync_r2 <= sync_r1;
    end
  end

  // Per-key next-state, counter and output decode.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
      out_s[i]   = key_out_r[i];
      case (state_r[i])
        S_HIGH: begin
          if (!sync_r2[i]) begin
            state_s[i] = S_FALL;
            cnt_s[i]   = {CNT_W{1'b0}};
          end else begin
            out_s[i] = 1'b1;
          end
        end
        S_FALL: begin
          if (sync_r2[i]) begin
            state_s[i] = S_HIGH;
            cnt_s[i]   = {CNT_W{1'b0}};
          end else if (cnt_r[i] == CNT_LAST) begin
            state_s[i] = S_LOW;
            out_s[i]   = 1'b0;
            cnt_s[i]   = {CNT_W{1'b0}};
          end else begin
            cnt_s[i] = cnt_r[i] + CNT_W'(1);
          end
        end
        S_LOW: begin
          if (sync_r2[i]) begin
            state_s[i] = S_RISE;
            cnt_s[i]   = {CNT_W{1'b0}};
          end else begin
            out_s[i] = 1'b0;
          end
        end
        S_RISE: begin
          if (!sync_r2[i]) begin
            state_s[i] = S_LOW;
            cnt_s[i]   = {CNT_W{1'b0}};
          end else if (cnt_r[i] == CNT_LAST) begin
            state_s[i] = S_HIGH;
            out_s[i]   = 1'b1;
            cnt_s[i]   = {CNT_W{1'b0}};
          end else begin
            cnt_s[i] = cnt_r[i] + CNT_W'(1);
          end
        end
        default: begin
          state_s[i] = S_HIGH;
          cnt_s[i]   = {CNT_W{1'b0}};
          out_s[i]   = 1'b1;
        end
      endcase
      // Busy is registered from the next state so it tracks state_r exactly.
      busy_s[i] = (state_s[i] == S_FALL) || (state_s[i] == S_RISE);
    end
  end

  // Filter state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        state_r[i] <= S_HIGH;
        cnt_r[i]   <= {CNT_W{1'b0}};
      end
      key_out_r  <= 4'b1111;
      key_busy_r <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
      end
      key_out_r  <= out_s;
      key_busy_r <= busy_s;
    end
  end

  assign key_out  = key_out_r;
  assign key_busy = key_busy_r;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX=8: every change is expected
// exactly 10 edges after the input moves (edge 0 = first edge after the change).
module tb_key_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_out;
  logic [3:0] key_busy;

  int checks   = 0;
  int failures = 0;

  key_debounce #(.CNT_MAX(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_out  (key_out),
    .key_busy (key_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] eb;
    rst_n  = 1'b0;
    key_in = 4'b0000;
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (key_out !== 4'b1111) begin
        failures++;
        $display("FAIL reset_out j=%0d got=%b exp=%b", j, key_out, 4'b1111);
      end
      checks++;
      if (key_busy !== 4'b0000) begin
        failures++;
        $display("FAIL reset_busy j=%0d got=%b exp=%b", j, key_busy, 4'b0000);
      end
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (key_out !== 4'b1111 || key_busy !== 4'b0000) begin
      failures++;
      $display("FAIL reset_first_edge got=%b/%b exp=1111/0000", key_out, key_busy);
    end
    // The short low that leaked through the synchronizer must be rejected.
    key_in = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      tick();
      eb = (k == 2) ? 4'b1111 : 4'b0000;
      checks++;
      if (key_out !== 4'b1111 || key_busy !== eb) begin
        failures++;
        $display("FAIL reset_settle k=%0d got=%b/%b exp=1111/%b", k, key_out, key_busy, eb);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] eo, eb;
    key_in = 4'b1110;
    for (int j = 0; j < 12; j++) begin
      tick();
      eo = (j >= 10) ? 4'b1110 : 4'b1111;
      eb = (j >= 2 && j <= 9) ? 4'b0001 : 4'b0000;
      checks++;
      if (key_out !== eo) begin
        failures++;
        $display("FAIL press_out j=%0d got=%b exp=%b", j, key_out, eo);
      end
      checks++;
      if (key_busy !== eb) begin
        failures++;
        $display("FAIL press_busy j=%0d got=%b exp=%b", j, key_busy, eb);
      end
    end
  endtask

  task automatic test_release_glitch();
    logic [3:0] eo, eb;
    for (int j = 0; j < 21; j++) begin
      key_in = (j >= 6 && j <= 8) ? 4'b1110 : 4'b1111;
      tick();
      eo = (j >= 19) ? 4'b1111 : 4'b1110;
      eb = ((j >= 2 && j <= 7) || (j >= 11 && j <= 18)) ? 4'b0001 : 4'b0000;
      checks++;
      if (key_out !== eo) begin
        failures++;
        $display("FAIL glitch_out j=%0d got=%b exp=%b", j, key_out, eo);
      end
      checks++;
      if (key_busy !== eb) begin
        failures++;
        $display("FAIL glitch_busy j=%0d got=%b exp=%b", j, key_busy, eb);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] eb;
    for (int j = 0; j < 18; j++) begin
      key_in = (j <= 4 || (j >= 7 && j <= 11)) ? 4'b1101 : 4'b1111;
      tick();
      eb = ((j >= 2 && j <= 6) || (j >= 9 && j <= 13)) ? 4'b0010 : 4'b0000;
      checks++;
      if (key_out !== 4'b1111) begin
        failures++;
        $display("FAIL bounce_out j=%0d got=%b exp=%b", j, key_out, 4'b1111);
      end
      checks++;
      if (key_busy !== eb) begin
        failures++;
        $display("FAIL bounce_busy j=%0d got=%b exp=%b", j, key_busy, eb);
      end
    end
  endtask

  task automatic test_parallel();
    logic [3:0] eo, eb;
    key_in = 4'b0000;
    for (int j = 0; j < 12; j++) begin
      tick();
      eo = (j >= 10) ? 4'b0000 : 4'b1111;
      eb = (j >= 2 && j <= 9) ? 4'b1111 : 4'b0000;
      checks++;
      if (key_out !== eo || key_busy !== eb) begin
        failures++;
        $display("FAIL parallel_press j=%0d got=%b/%b exp=%b/%b", j, key_out, key_busy, eo, eb);
      end
    end
    key_in = 4'b1000;
    for (int j = 0; j < 12; j++) begin
      tick();
      eo = (j >= 10) ? 4'b1000 : 4'b0000;
      eb = (j >= 2 && j <= 9) ? 4'b1000 : 4'b0000;
      checks++;
      if (key_out !== eo || key_busy !== eb) begin
        failures++;
        $display("FAIL parallel_key3 j=%0d got=%b/%b exp=%b/%b", j, key_out, key_busy, eo, eb);
      end
    end
  endtask

  task automatic test_release();
    logic [3:0] eo, eb;
    key_in = 4'b1111;
    for (int j = 0; j < 12; j++) begin
      tick();
      eo = (j >= 10) ? 4'b1111 : 4'b1000;
      eb = (j >= 2 && j <= 9) ? 4'b0111 : 4'b0000;
      checks++;
      if (key_out !== eo || key_busy !== eb) begin
        failures++;
        $display("FAIL release j=%0d got=%b/%b exp=%b/%b", j, key_out, key_busy, eo, eb);
      end
    end
  endtask

  task automatic test_reset_mid_filter();
    logic [3:0] eo, eb;
    key_in = 4'b1011;
    for (int j = 0; j <= 6; j++) begin
      tick();
      eb = (j >= 2) ? 4'b0100 : 4'b0000;
      checks++;
      if (key_out !== 4'b1111 || key_busy !== eb) begin
        failures++;
        $display("FAIL midrst_pre j=%0d got=%b/%b exp=1111/%b", j, key_out, key_busy, eb);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (key_out !== 4'b1111 || key_busy !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_async got=%b/%b exp=1111/0000", key_out, key_busy);
    end
    tick();
    checks++;
    if (key_out !== 4'b1111 || key_busy !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_hold got=%b/%b exp=1111/0000", key_out, key_busy);
    end
    rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      eo = (j >= 10) ? 4'b1011 : 4'b1111;
      eb = (j >= 2 && j <= 9) ? 4'b0100 : 4'b0000;
      checks++;
      if (key_out !== eo || key_busy !== eb) begin
        failures++;
        $display("FAIL midrst_post j=%0d got=%b/%b exp=%b/%b", j, key_out, key_busy, eo, eb);
      end
    end
    key_in = 4'b1111;
    for (int j = 0; j < 12; j++) begin
      tick();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    key_in = 4'b1111;
    test_reset();
    test_clean_press();
    test_release_glitch();
    test_bounce();
    test_parallel();
    test_release();
    test_reset_mid_filter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Debounces the four DE1-SoC push-buttons KEY[3:0] (active-low, mechanically bouncy).
- Delivers clean, glitch-free, active-low levels directly to the falling-edge detector stage, which turns each press into a one-cycle flag for game control.
- Each key is filtered independently:
  - a 2-FF synchronizer feeds a per-key 4-state FSM;
  - a per-key stability counter qualifies every transition.

Parameters:
- CNT_MAX, 1000000, number of consecutive stable synchronized samples required to accept a level change (20 ms at 50 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 20, width of each per-key stability counter.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  reset; asynchronous, active-low.
- key_in  input  4  raw button levels, asynchronous to clk, 0 = pressed.
- key_out  output  4  debounced levels, registered, 0 = pressed; feeds the edge-detector key0..key3 inputs.
- key_busy  output  4  1 while key i is in a filtering state (S_FALL or S_RISE); debug/LED use.

Behaviour:
- Reset (async assert, sync-free release):
  - sync_r1, sync_r2 = 4'b1111; all FSMs in S_HIGH; all counters = 0.
  - key_out = 4'b1111; key_busy = 4'b0000.
  - Outputs are held while rst_n = 0.
- Synchronizer: sync_r1 <= key_in; sync_r2 <= sync_r1. Call s[i] = sync_r2[i]. Nothing downstream uses key_in directly.
- Per-key FSM, all transitions on the rising edge of clk:
  - S_HIGH (key_out=1): if s=0, go to S_FALL, cnt<=0; else stay.
  - S_FALL (key_out=1, busy=1):
    - if s=1: bounce; go to S_HIGH, cnt<=0.
    - else if cnt==CNT_MAX-1: go to S_LOW, key_out<=0, cnt<=0.
    - else cnt<=cnt+1.
  - S_LOW (key_out=0): if s=1, go to S_RISE, cnt<=0; else stay.
  - S_RISE (key_out=0, busy=1):
    - if s=0: go to S_LOW, cnt<=0.
    - else if cnt==CNT_MAX-1: go to S_HIGH, key_out<=1, cnt<=0.
    - else cnt<=cnt+1.
- Latency:
  - A raw level captured into sync_r1 at edge E0 reaches s at E1 and enters the filter state at E2.
  - key_out changes at edge E2+CNT_MAX, provided s holds for the whole window. Total = CNT_MAX+2 cycles.
  - Same latency for press and release.
- Bounce rejection: any opposite sample during filtering aborts the window and returns to the prior stable state with the counter cleared. There is no partial credit; the next window restarts from 0.
- CNT_MAX=1: a change is accepted one cycle after entering the filter state; a single-cycle glitch still reaches the filter state but is rejected if s reverts on the next sample.
- Counters never wrap: the maximum value reached is CNT_MAX-1, so CNT_W must cover CNT_MAX-1.
- Keys are fully independent. Simultaneous changes on several keys filter in parallel, with identical timing per key.
- key_out is a direct register output: glitch-free, no combinational path from key_in.
- Reset mid-filter: the window is abandoned and key_out returns to 1 immediately. After release, a still-held button must pass a full CNT_MAX+2 window again.

Test Plan (CNT_MAX=8, CNT_W=4 for simulation):
- Reset: assert rst_n=0 with key_in=4'b0000 -> key_out=4'b1111, key_busy=4'b0000 throughout reset and on the first edge after release.
- Clean press: key_in[0] 1->0 before edge E0, held -> key_out[0]=0 exactly at E10; key_busy[0]=1 from E2 to E9; other bits unchanged.
- Bounce reject: key_in[1] low for 5 cycles, high 2 cycles, low 5 cycles, then high -> key_out[1] stays 1; key_busy[1] pulses; counter restarts each time.
- Release: from the pressed state, key_in[0] 0->1 held -> key_out[0]=1 exactly 10 cycles later; a 3-cycle low glitch at cycle 6 of the window instead keeps key_out[0]=0.
- Parallel keys: key_in 1111->0000 simultaneously -> key_out=0000 on the same edge (E10); then release only key 3 -> key_out=1000 after 10 cycles.
- Reset mid-filter: press key 2; at cycle 6 pulse rst_n low for 1 cycle while the key is held -> key_out[2]=1 during reset; key_out[2]=0 exactly 10 cycles after rst_n release.
